// File: rtl/cpu_pkg.sv
// Shared widths and fetch FSM encoding for the instruction fetch front end.
package cpu_pkg;
  localparam int ADDR_W  = 14;
  localparam int INSTR_W = 32;
  localparam int FETCH_W = INSTR_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// Output register with a one-entry skid buffer; flush empties both stages.
// Handshake: in_valid is taken only while in_ready; out_stall freezes out_valid/out_data.
module fetch_skid #(
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_stall,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_stall) begin
      // A parked word always drains before any new word can arrive.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: PC, request FSM and branch kill logic.
// Handshake: imem_req/imem_addr held until imem_gnt; one imem_rvalid returns per grant.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 14'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  ins_br_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  ins_inc_addr
);
  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                kill_q, kill_d;
  logic                branch_kill;
  logic                accept;
  logic                skid_ready;
  logic [FETCH_W-1:0]  out_data;

  // A branch only needs a kill when a response is still owed to us.
  assign branch_kill = ((state_q == ST_WAIT) && !imem_rvalid) ||
                       ((state_q == ST_REQ) && imem_gnt);
  assign accept = (state_q == ST_WAIT) && imem_rvalid && !kill_q &&
                  !br_taken && skid_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    case (state_q)
      ST_REQ:  if (imem_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || !stall) state_d = ST_REQ;
          else                  state_d = ST_HOLD;
        end
      end
      ST_HOLD: if (!stall) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
    if (accept) pc_d = next_addr(pc_q);
    if (br_taken) begin
      pc_d    = ins_br_addr;
      kill_d  = branch_kill;
      state_d = branch_kill ? ST_WAIT : ST_REQ;
    end
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ);
    imem_addr = pc_q;
  end

  fetch_skid #(.W(FETCH_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (br_taken),
    .in_valid  (accept),
    .in_ready  (skid_ready),
    .in_data   ({imem_rdata, pc_q}),
    .out_valid (if_valid),
    .out_stall (stall),
    .out_data  (out_data)
  );

  assign if_instr     = out_data[FETCH_W-1:ADDR_W];
  assign if_pc        = out_data[ADDR_W-1:0];
  assign ins_inc_addr = next_addr(if_pc);
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: streaming, stall/skid, branches, wrap and reset.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [13:0] ins_br_addr;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [13:0] if_pc;
  logic [13:0] ins_inc_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_taken     (br_taken),
    .ins_br_addr  (ins_br_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .ins_inc_addr (ins_inc_addr)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {4'hA, a, ~a};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One grant, one response a cycle later, stall low throughout.
  task automatic fetch_one(input logic [13:0] p);
    logic [13:0] nxt;
    nxt = p + 14'd1;
    check("req_high", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(p));
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("wait_no_req", 32'(imem_req), 32'd0);
    check("idle_invalid", 32'(if_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(p);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    check("out_valid", 32'(if_valid), 32'd1);
    check("out_pc", 32'(if_pc), 32'(p));
    check("out_instr", if_instr, mem_word(p));
    check("inc_addr", 32'(ins_inc_addr), 32'(nxt));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; ins_br_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step();
    step();
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", 32'(if_pc), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_inc", 32'(ins_inc_addr), 32'd1);
    rst_n = 1'b1;

    // Plain stream.
    for (int i = 0; i < 4; i++) fetch_one(14'(i));

    // Stall across the response: word 3 frozen, word 4 parked in skid.
    imem_gnt = 1'b1; stall = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("stall_hold_valid", 32'(if_valid), 32'd1);
    check("stall_hold_pc", 32'(if_pc), 32'd3);
    imem_rvalid = 1'b1; imem_rdata = mem_word(14'd4);
    step();
    imem_rvalid = 1'b0;
    check("hold_no_req", 32'(imem_req), 32'd0);
    check("hold_pc", 32'(if_pc), 32'd3);
    check("hold_instr", if_instr, mem_word(14'd3));
    step();
    check("hold2_no_req", 32'(imem_req), 32'd0);
    check("hold2_valid", 32'(if_valid), 32'd1);
    check("hold2_pc", 32'(if_pc), 32'd3);
    stall = 1'b0;
    step();
    check("skid_valid", 32'(if_valid), 32'd1);
    check("skid_pc", 32'(if_pc), 32'd4);
    check("skid_instr", if_instr, mem_word(14'd4));
    fetch_one(14'd5);

    // Branch while waiting: in-flight word 6 must be dropped.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    br_taken = 1'b1; ins_br_addr = 14'h0100;
    step();
    br_taken = 1'b0;
    check("br_wait_invalid", 32'(if_valid), 32'd0);
    check("br_wait_no_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(14'd6);
    step();
    imem_rvalid = 1'b0;
    check("kill_drop_valid", 32'(if_valid), 32'd0);
    fetch_one(14'h0100);

    // Branch in REQ without grant: address changes, no kill.
    br_taken = 1'b1; ins_br_addr = 14'h0200;
    step();
    br_taken = 1'b0;
    check("br_req_invalid", 32'(if_valid), 32'd0);
    fetch_one(14'h0200);

    // Branch coincident with response under stall: branch wins.
    imem_gnt = 1'b1; stall = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("stall_wait_valid", 32'(if_valid), 32'd1);
    imem_rvalid = 1'b1; imem_rdata = mem_word(14'h0201);
    br_taken = 1'b1; ins_br_addr = 14'h0300;
    step();
    imem_rvalid = 1'b0; br_taken = 1'b0;
    check("br_rv_invalid", 32'(if_valid), 32'd0);
    stall = 1'b0;
    fetch_one(14'h0300);

    // Response outside WAIT is ignored.
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("stray_rv_valid", 32'(if_valid), 32'd0);
    check("stray_rv_addr", 32'(imem_addr), 32'h0301);

    // Address wrap at the top of the space.
    br_taken = 1'b1; ins_br_addr = 14'h3FFF;
    step();
    br_taken = 1'b0;
    fetch_one(14'h3FFF);
    check("wrap_addr", 32'(imem_addr), 32'd0);
    fetch_one(14'd0);

    // Reset pulse during WAIT, then a late response.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_req", 32'(imem_req), 32'd1);
    check("rst2_addr", 32'(imem_addr), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(14'd1);
    step();
    imem_rvalid = 1'b0;
    check("late_rv_valid", 32'(if_valid), 32'd0);
    check("late_rv_addr", 32'(imem_addr), 32'd0);
    fetch_one(14'd0);
    fetch_one(14'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Ports, one per line:
  clk  in  1  rising-edge clock.
  rst_n  in  1  synchronous active-low reset.
  stall  in  1  decode not ready; holds the fetch output register.
  br_taken  in  1  branch resolved taken this cycle.
  ins_br_addr  in  14  branch target word address.
  imem_req  out  1  instruction-memory request.
  imem_addr  out  14  request word address.
  imem_gnt  in  1  request accepted this cycle.
  imem_rvalid  in  1  read data valid; arrives 1 or more cycles after grant.
  imem_rdata  in  32  instruction word.
  if_valid  out  1  if_instr and if_pc are valid.
  if_instr  out  32  fetched instruction.
  if_pc  out  14  address of if_instr.
  ins_inc_addr  out  14  if_pc+1, combinational.
REQ-003 Parameter: RESET_PC, default 14'd0, meaning the first fetch address after reset.

Function
REQ-004 The block SHALL hold one PC register (pc) and allow at most one outstanding memory request.
REQ-005 The FSM SHALL have three states:
  REQ: imem_req=1 and imem_addr=pc; on imem_gnt go to WAIT.
  WAIT: wait for imem_rvalid.
  HOLD: skid buffer full, imem_req=0.
REQ-006 In WAIT, on imem_rvalid with no kill, the block SHALL increment pc modulo 2^14 (16383 wraps to 0).
  If the output register is free or freed this cycle (stall=0): load the output register, set if_valid=1 the next cycle, and go to REQ.
  Otherwise: load the skid buffer and go to HOLD.
REQ-007 In HOLD, when stall=0 the block SHALL move the skid buffer into the output register (if_valid stays 1) and go to REQ in the same cycle.
REQ-008 While stall=1, the block SHALL hold if_valid, if_instr and if_pc unchanged.
REQ-009 While stall=0 with no new data, the output register SHALL go invalid the next cycle.
REQ-010 The latency from imem_rvalid to if_valid SHALL be exactly 1 cycle when stall=0.
REQ-011 On br_taken=1, the following SHALL happen in the same edge, regardless of stall and state:
  - pc <= ins_br_addr.
  - if_valid <= 0.
  - skid buffer cleared.
  - If in WAIT, or in REQ with imem_gnt high that cycle, a kill flag is set; otherwise the next state is REQ.
REQ-012 While the kill flag is set, the block SHALL discard the next imem_rvalid: no pc increment, no output load. It SHALL then clear kill and go to REQ.
REQ-013 br_taken and imem_rvalid in the same cycle: the returning word SHALL be discarded and the branch SHALL win.
REQ-014 In REQ, br_taken with imem_gnt=0 SHALL change imem_addr to the new pc on the next cycle with no kill.
REQ-015 imem_rvalid outside WAIT SHALL be ignored.
REQ-016 ins_inc_addr SHALL equal (if_pc+1) mod 2^14 at all times, including while if_valid=0.

Reset
REQ-017 While rst_n=0 at a clock edge, the block SHALL set:
  - state=REQ, pc=RESET_PC, kill=0.
  - if_valid=0, if_instr=0, if_pc=0, skid buffer empty.
REQ-018 In the first cycle after rst_n rises, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-019 Reset asserted mid-request SHALL abandon the request; a late imem_rvalid in REQ SHALL be ignored.

Structure
REQ-020 A shared cpu package SHALL hold:
  - the address width constant (14) and instruction width constant (32);
  - the FSM state encoding type (REQ, WAIT, HOLD).
REQ-021 The output-register-plus-skid-buffer SHALL be one sub-module, fetch_skid, with in-valid/in-ready and out-valid/out-stall sides, parameterised on data width (46 = 32+14).
REQ-022 The pc, FSM and kill logic SHALL remain in pc_fetch.

Verification
REQ-023 Reset then stream, gnt always 1, rvalid 1 cycle after gnt, stall=0 -> if_pc 0,1,2,... with if_instr matching memory; ins_inc_addr=if_pc+1.
REQ-024 Stall raised for 3 cycles while a response returns -> HOLD entered, imem_req=0, outputs frozen; after release the skid word appears in order with no loss or duplicate.
REQ-025 br_taken to 14'h0100 while in WAIT -> the in-flight word is dropped, if_valid=0 next cycle, next imem_addr=0x100, next if_pc=0x100.
REQ-026 br_taken coincident with imem_rvalid and stall=1 -> branch wins, old word discarded, if_valid cleared despite stall.
REQ-027 pc=16383 fetched -> next imem_addr=0 and ins_inc_addr=0 while if_pc=16383.
REQ-028 rst_n low for 1 cycle during WAIT, then a late rvalid -> ignored; fetch restarts at RESET_PC.
